// File: rtl/vga_frame_monitor.sv
`default_nettype none
// ============================================================================
// vga_frame_monitor : measures per-frame active geometry and pixel checksum.
// Optional checksum logic: define VGA_FRAME_MONITOR_CHECKSUM_EN.   Rev 1.0
// ============================================================================
module vga_frame_monitor #(
    parameter int EXP_PIXELS = 256,
    parameter int EXP_LINES  = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    output logic        frame_valid,
    output logic [15:0] frame_cnt,
    output logic [9:0]  line_cnt,
    output logic        frame_err,
    output logic [15:0] frame_sum,
    output logic        locked
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        FRAME  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [11:0] PIX_MAX  = 12'hFFF;
    localparam logic [9:0]  LINE_MAX = 10'h3FF;
    localparam logic [11:0] EXP_PIX  = 12'(EXP_PIXELS);
    localparam logic [9:0]  EXP_LIN  = 10'(EXP_LINES);

    state_t      state_q, state_d;
    logic        hs_q, vs_q;
    logic [11:0] pix_q, pix_d;
    logic [9:0]  lines_q, lines_d;
    logic        err_q, err_d;
    logic        fvalid_q, fvalid_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic [9:0]  lcnt_q, lcnt_d;
    logic        ferr_q, ferr_d;
    logic        locked_q, locked_d;

    logic        w_hs_fall, w_vs_fall, w_vs_rise, w_pix_hit, w_line_close;

    assign w_hs_fall    = hs_q & ~hsync;
    assign w_vs_fall    = vs_q & ~vsync;
    assign w_vs_rise    = ~vs_q & vsync;
    assign w_pix_hit    = pix_en & hsync & vsync;
    // A falling vsync also closes a partial line, so the last line counts
    // even when hsync does not fall with it.
    assign w_line_close = (w_hs_fall | w_vs_fall) & (pix_q != 12'd0);

    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        lines_d  = lines_q;
        err_d    = err_q;
        fvalid_d = 1'b0;
        fcnt_d   = fcnt_q;
        lcnt_d   = lcnt_q;
        ferr_d   = ferr_q;
        locked_d = locked_q;
        case (state_q)
            HUNT: begin
                if (w_vs_rise) begin
                    state_d  = FRAME;
                    pix_d    = '0;
                    lines_d  = '0;
                    err_d    = 1'b0;
                    locked_d = 1'b1;
                end
            end
            FRAME: begin
                if (w_pix_hit && (pix_q != PIX_MAX)) begin
                    pix_d = pix_q + 12'd1;
                end
                if (w_line_close) begin
                    if (lines_q != LINE_MAX) begin
                        lines_d = lines_q + 10'd1;
                    end
                    if (pix_q != EXP_PIX) begin
                        err_d = 1'b1;
                    end
                    pix_d = '0;
                end
                if (w_vs_fall) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                fvalid_d = 1'b1;
                fcnt_d   = fcnt_q + 16'd1;
                lcnt_d   = lines_q;
                ferr_d   = err_q | (lines_q != EXP_LIN);
                pix_d    = '0;
                lines_d  = '0;
                err_d    = 1'b0;
                state_d  = FRAME;
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= HUNT;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            pix_q    <= '0;
            lines_q  <= '0;
            err_q    <= 1'b0;
            fvalid_q <= 1'b0;
            fcnt_q   <= '0;
            lcnt_q   <= '0;
            ferr_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hs_q     <= hsync;
            vs_q     <= vsync;
            pix_q    <= pix_d;
            lines_q  <= lines_d;
            err_q    <= err_d;
            fvalid_q <= fvalid_d;
            fcnt_q   <= fcnt_d;
            lcnt_q   <= lcnt_d;
            ferr_q   <= ferr_d;
            locked_q <= locked_d;
        end
    end

`ifdef VGA_FRAME_MONITOR_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    logic [15:0] fsum_q, fsum_d;

    always_comb begin
        sum_d  = sum_q;
        fsum_d = fsum_q;
        case (state_q)
            HUNT: begin
                if (w_vs_rise) begin
                    sum_d = '0;
                end
            end
            FRAME: begin
                if (w_pix_hit) begin
                    sum_d = {sum_q[14:0], sum_q[15]} ^ {13'b0, rgb};
                end
            end
            REPORT: begin
                fsum_d = sum_q;
                sum_d  = '0;
            end
            default: begin
                sum_d = sum_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_q  <= '0;
            fsum_q <= '0;
        end else begin
            sum_q  <= sum_d;
            fsum_q <= fsum_d;
        end
    end

    assign frame_sum = fsum_q;
`else
    logic w_unused_rgb;
    assign w_unused_rgb = ^rgb;
    assign frame_sum    = '0;
`endif

    assign frame_valid = fvalid_q;
    assign frame_cnt   = fcnt_q;
    assign line_cnt    = lcnt_q;
    assign frame_err   = ferr_q;
    assign locked      = locked_q;

endmodule
`default_nettype wire
